// File: rtl/axi_wr_slave.sv
// axi_wr_slave: AXI4 write-channel responder with a single transaction outstanding.
// It accepts one AW command, absorbs its W beats into a synchronous memory write port
// (INCR addressing, one mem_we pulse per beat) and then returns a B response.
//
// Ports:
//   aclk, aresetn                       clock, asynchronous active-low reset
//   awaddr/awlen/awsize/awid, awvalid   write command in; awready out
//   wdata/wstrb/wlast, wvalid           write data beat in; wready out
//   bresp/bid, bvalid                   write response out; bready in
//   mem_we/mem_addr/mem_wdata/mem_wstrb registered memory write port
module axi_wr_slave #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int STRB_W  = DATA_W / 8,
   parameter int LEN_W   = 8,
   parameter int ASIZE_W = 3,
   parameter int ID_W    = 4,
   parameter int RESP_W  = 2
) (
   input  logic               aclk,
   input  logic               aresetn,
   input  logic [ADDR_W-1:0]  awaddr,
   input  logic [LEN_W-1:0]   awlen,
   input  logic [ASIZE_W-1:0] awsize,
   input  logic [ID_W-1:0]    awid,
   input  logic               awvalid,
   output logic               awready,
   input  logic [DATA_W-1:0]  wdata,
   input  logic [STRB_W-1:0]  wstrb,
   input  logic               wlast,
   input  logic               wvalid,
   output logic               wready,
   output logic [RESP_W-1:0]  bresp,
   output logic [ID_W-1:0]    bid,
   output logic               bvalid,
   input  logic               bready,
   output logic               mem_we,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic [DATA_W-1:0]  mem_wdata,
   output logic [STRB_W-1:0]  mem_wstrb
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StData = 2'd1;
   localparam logic [1:0] StResp = 2'd2;

   // Largest legal awsize: one full data-bus word per beat.
   localparam logic [ASIZE_W-1:0] MaxSize = ASIZE_W'($clog2(STRB_W));

   localparam logic [RESP_W-1:0] RespOkay   = RESP_W'(0);
   localparam logic [RESP_W-1:0] RespSlverr = RESP_W'(2);

   logic [1:0]         state_q, state_d;
   logic [ADDR_W-1:0]  cur_addr_q, cur_addr_d;
   logic [LEN_W-1:0]   awlen_q, awlen_d;
   logic [ASIZE_W-1:0] awsize_q, awsize_d;
   logic [ID_W-1:0]    awid_q, awid_d;
   logic [LEN_W-1:0]   beat_cnt_q, beat_cnt_d;
   logic               err_q, err_d;
   logic               mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
   logic [STRB_W-1:0]  mem_wstrb_q, mem_wstrb_d;
   logic [RESP_W-1:0]  bresp_q, bresp_d;
   logic [ID_W-1:0]    bid_q, bid_d;

   logic oversize;
   logic is_last;
   logic err_beat;

   // Oversized bursts are still drained, but never reach memory.
   assign oversize = (awsize_q > MaxSize);

   always_comb begin
      state_d     = state_q;
      cur_addr_d  = cur_addr_q;
      awlen_d     = awlen_q;
      awsize_d    = awsize_q;
      awid_d      = awid_q;
      beat_cnt_d  = beat_cnt_q;
      err_d       = err_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_wstrb_d = mem_wstrb_q;
      bresp_d     = bresp_q;
      bid_d       = bid_q;
      is_last     = 1'b0;
      err_beat    = 1'b0;

      case (state_q)
         StIdle: begin
            if (awvalid) begin
               cur_addr_d = awaddr;
               awlen_d    = awlen;
               awsize_d   = awsize;
               awid_d     = awid;
               beat_cnt_d = '0;
               err_d      = (awsize > MaxSize);
               state_d    = StData;
            end
         end
         StData: begin
            if (wvalid) begin
               is_last     = (beat_cnt_q == awlen_q);
               mem_addr_d  = cur_addr_q;
               mem_wdata_d = wdata;
               mem_wstrb_d = wstrb;
               mem_we_d    = !oversize;
               cur_addr_d  = cur_addr_q + (ADDR_W'(1) << awsize_q);
               beat_cnt_d  = beat_cnt_q + LEN_W'(1);
               // wlast must be high on exactly the final beat.
               err_beat    = is_last ? !wlast : wlast;
               err_d       = err_q | err_beat;
               if (is_last) begin
                  bid_d   = awid_q;
                  bresp_d = (err_q | err_beat) ? RespSlverr : RespOkay;
                  state_d = StResp;
               end
            end
         end
         StResp: begin
            if (bready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q     <= StIdle;
         cur_addr_q  <= '0;
         awlen_q     <= '0;
         awsize_q    <= '0;
         awid_q      <= '0;
         beat_cnt_q  <= '0;
         err_q       <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_wstrb_q <= '0;
         bresp_q     <= '0;
         bid_q       <= '0;
      end else begin
         state_q     <= state_d;
         cur_addr_q  <= cur_addr_d;
         awlen_q     <= awlen_d;
         awsize_q    <= awsize_d;
         awid_q      <= awid_d;
         beat_cnt_q  <= beat_cnt_d;
         err_q       <= err_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wstrb_q <= mem_wstrb_d;
         bresp_q     <= bresp_d;
         bid_q       <= bid_d;
      end
   end

   assign awready   = (state_q == StIdle);
   assign wready    = (state_q == StData);
   assign bvalid    = (state_q == StResp);
   assign bresp     = bresp_q;
   assign bid       = bid_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_wstrb = mem_wstrb_q;

endmodule
